systolic_pe_db: RTL and testbench

Parametrised weight-stationary processing element for the systolic matrix-multiply array. Successor to the fixed-width PE, with the following additions:
- configurable operand and accumulator widths, and signed/unsigned arithmetic;
- valid bits travelling with data;
- a double-buffered stationary weight, so the next tile's weights preload during PROCESS;
- a sticky alignment-error flag.

One instance per array cell. Activations flow left to right, partial sums top to bottom, weights down a dedicated chain.

---
 rtl/systolic_pe_db.sv | 102 ++++++++++
 tb/tb_systolic_pe_db.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_pe_db.sv
// systolic_pe_db: weight-stationary PE with a double-buffered weight, valid tracking and a sticky error flag.
// Define PE_SAT_EN to saturate the PROCESS sum instead of wrapping it.
module systolic_pe_db #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        mode_i,
    input  logic              add_zero_i,
    input  logic [DATA_W-1:0] left_data_i,
    input  logic              left_valid_i,
    input  logic [ACC_W-1:0]  top_psum_i,
    input  logic              top_valid_i,
    input  logic [DATA_W-1:0] w_i,
    input  logic              w_valid_i,
    input  logic              swap_i,
    output logic [DATA_W-1:0] right_data_o,
    output logic              right_valid_o,
    output logic [ACC_W-1:0]  bottom_psum_o,
    output logic              bottom_valid_o,
    output logic [DATA_W-1:0] w_o,
    output logic              w_valid_o,
    output logic              err_o
);
    if (ACC_W < 2*DATA_W) begin : g_acc_w_check
        $error("systolic_pe_db: ACC_W must be at least 2*DATA_W");
    end

    // mode 11 (HOLD) falls through every branch below and keeps the bottom outputs
    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_PROC = 2'b10;

    logic [DATA_W-1:0]       active;
    logic [DATA_W-1:0]       shadow;
    logic                    shadow_full;
    logic signed [ACC_W-1:0] prod_s;
    logic [ACC_W-1:0]        prod_u;
    logic [ACC_W-1:0]        prod;
    logic [ACC_W-1:0]        addend;
    logic [ACC_W-1:0]        sum;
    logic                    align_err;
    logic                    swap_err;

    // operands widened first so the low ACC_W bits hold the exact product
    assign prod_s = ACC_W'($signed(active)) * ACC_W'($signed(left_data_i));
    assign prod_u = ACC_W'(active) * ACC_W'(left_data_i);
    assign prod   = (SIGNED != 0) ? prod_s : prod_u;
    assign addend = add_zero_i ? '0 : top_psum_i;

`ifdef PE_SAT_EN
    logic [ACC_W:0] sum_full;
    logic           ovf_s;
    assign sum_full = {1'b0, prod} + {1'b0, addend};
    assign ovf_s    = (prod[ACC_W-1] == addend[ACC_W-1]) && (sum_full[ACC_W-1] != prod[ACC_W-1]);
    assign sum = (SIGNED != 0)
               ? (ovf_s ? {prod[ACC_W-1], {(ACC_W-1){~prod[ACC_W-1]}}} : sum_full[ACC_W-1:0])
               : (sum_full[ACC_W] ? '1 : sum_full[ACC_W-1:0]);
`else
    assign sum = prod + addend;
`endif

    assign align_err = (mode_i == MODE_PROC) &&
                       (left_valid_i ? (!add_zero_i && !top_valid_i) : top_valid_i);
    assign swap_err  = swap_i && !shadow_full;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            right_data_o   <= '0;
            right_valid_o  <= 1'b0;
            bottom_psum_o  <= '0;
            bottom_valid_o <= 1'b0;
            w_o            <= '0;
            w_valid_o      <= 1'b0;
            err_o          <= 1'b0;
            active         <= '0;
            shadow         <= '0;
            shadow_full    <= 1'b0;
        end else begin
            right_data_o  <= left_data_i;
            right_valid_o <= left_valid_i;
            w_o           <= w_i;
            w_valid_o     <= w_valid_i;
            if (w_valid_i) shadow <= w_i;
            if (swap_i && shadow_full) active <= shadow;
            // a fresh weight arriving with the swap refills the shadow immediately
            shadow_full <= w_valid_i || (shadow_full && !swap_i);
            err_o       <= err_o || swap_err || align_err;
            if (mode_i == MODE_PASS) begin
                bottom_psum_o  <= top_psum_i;
                bottom_valid_o <= top_valid_i;
            end else if (mode_i == MODE_LOAD) begin
                bottom_valid_o <= 1'b0;
            end else if (mode_i == MODE_PROC) begin
                bottom_psum_o  <= sum;
                bottom_valid_o <= left_valid_i && (add_zero_i || top_valid_i);
            end
        end
    end
endmodule

// File: tb/tb_systolic_pe_db.sv
// tb_systolic_pe_db: directed checks plus randomized stimulus against a behavioural model.
module tb_systolic_pe_db;
    localparam logic [1:0] PASS = 2'b00, LOAD = 2'b01, PROC = 2'b10, HOLD = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mode = PASS;
    logic        add_zero = 1'b0;
    logic [7:0]  left_data = '0;
    logic        left_valid = 1'b0;
    logic [31:0] top_psum = '0;
    logic        top_valid = 1'b0;
    logic [7:0]  w = '0;
    logic        w_valid = 1'b0;
    logic        swap = 1'b0;
    logic [7:0]  right_data;
    logic        right_valid;
    logic [31:0] bottom_psum;
    logic        bottom_valid;
    logic [7:0]  w_out;
    logic        w_valid_out;
    logic        err;

    int tests = 0;
    int fails = 0;

    logic [7:0]  m_active = '0, m_shadow = '0;
    bit          m_full = 0, m_err = 0;
    logic [7:0]  e_rdata = '0, e_w = '0;
    bit          e_rvalid = 0, e_wvalid = 0, e_bvalid = 0;
    logic [31:0] e_bpsum = '0;

    systolic_pe_db #(.DATA_W(8), .ACC_W(32), .SIGNED(1)) dut (
        .clk_i(clk), .rst_i(rst), .mode_i(mode), .add_zero_i(add_zero),
        .left_data_i(left_data), .left_valid_i(left_valid),
        .top_psum_i(top_psum), .top_valid_i(top_valid),
        .w_i(w), .w_valid_i(w_valid), .swap_i(swap),
        .right_data_o(right_data), .right_valid_o(right_valid),
        .bottom_psum_o(bottom_psum), .bottom_valid_o(bottom_valid),
        .w_o(w_out), .w_valid_o(w_valid_out), .err_o(err)
    );

    always #5 clk = ~clk;

    // reference model: applies the current inputs at the coming edge, then waits past it
    task automatic cycle();
        longint p, s;
        e_rdata  = left_data;
        e_rvalid = left_valid;
        e_w      = w;
        e_wvalid = w_valid;
        if (mode == PROC) begin
            p = longint'($signed(m_active)) * longint'($signed(left_data));
            s = p + (add_zero ? 64'sd0 : longint'($signed(top_psum)));
`ifdef PE_SAT_EN
            if (s > 64'sd2147483647) s = 64'sd2147483647;
            if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
            e_bpsum  = s[31:0];
            e_bvalid = left_valid && (add_zero || top_valid);
            if ((left_valid && !add_zero && !top_valid) || (!left_valid && top_valid)) m_err = 1;
        end else if (mode == PASS) begin
            e_bpsum  = top_psum;
            e_bvalid = top_valid;
        end else if (mode == LOAD) begin
            e_bvalid = 0;
        end
        if (swap) begin
            if (m_full) begin
                m_active = m_shadow;
                m_full   = 0;
            end else m_err = 1;
        end
        if (w_valid) begin
            m_shadow = w;
            m_full   = 1;
        end
        if (rst) begin
            m_active = '0; m_shadow = '0; m_full = 0; m_err = 0;
            e_rdata = '0; e_rvalid = 0; e_w = '0; e_wvalid = 0; e_bpsum = '0; e_bvalid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; mode = PASS; add_zero = 0; left_data = '0; left_valid = 0;
        top_psum = '0; top_valid = 0; w = '0; w_valid = 0; swap = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    task automatic load_and_swap(input logic [7:0] wt);
        idle(); mode = LOAD; w = wt; w_valid = 1;
        cycle();
        idle(); mode = LOAD; swap = 1;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        mode = PROC; left_data = 8'h55; left_valid = 1; top_psum = 32'h1234; top_valid = 1;
        w = 8'h77; w_valid = 1; swap = 1; rst = 1;
        cycle();
        idle();
        tests++;
        if ({right_data, right_valid, bottom_psum, bottom_valid, w_out, w_valid_out, err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got rd=%h rv=%b bp=%h bv=%b w=%h wv=%b err=%b, want all 0",
                     right_data, right_valid, bottom_psum, bottom_valid, w_out, w_valid_out, err);
        end
    endtask

    task automatic test_basic_mac();
        do_reset();
        load_and_swap(8'd3);
        mode = PROC; left_data = 8'd5; left_valid = 1; top_psum = 32'd10; top_valid = 1;
        cycle();
        idle();
        tests++;
        if (bottom_psum !== 32'd25) begin fails++; $display("FAIL basic_psum: got %0d want 25", bottom_psum); end
        tests++;
        if (bottom_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b want 1", bottom_valid); end
        tests++;
        if (right_data !== 8'd5) begin fails++; $display("FAIL basic_right_data: got %0d want 5", right_data); end
    endtask

    task automatic test_signed();
        do_reset();
        load_and_swap(8'hFE);
        mode = PROC; left_data = 8'd7; left_valid = 1; add_zero = 1; top_psum = 32'hDEAD; top_valid = 0;
        cycle();
        idle();
        tests++;
        if (bottom_psum !== 32'hFFFFFFF2) begin fails++; $display("FAIL signed_psum: got %h want fffffff2", bottom_psum); end
        tests++;
        if (bottom_valid !== 1'b1 || err !== 1'b0) begin
            fails++; $display("FAIL signed_flags: got bv=%b err=%b want bv=1 err=0", bottom_valid, err);
        end
    endtask

    task automatic test_swap_timing();
        do_reset();
        idle(); mode = LOAD; w = 8'd4; w_valid = 1;
        cycle();
        idle(); mode = LOAD; w = 8'd9; w_valid = 1; swap = 1;
        cycle();
        idle(); mode = PROC; left_data = 8'd2; left_valid = 1; add_zero = 1; swap = 1;
        cycle();
        tests++;
        if (bottom_psum !== 32'd8) begin fails++; $display("FAIL swap_cycle_psum: got %0d want 8", bottom_psum); end
        swap = 0;
        cycle();
        idle();
        tests++;
        if (bottom_psum !== 32'd18) begin fails++; $display("FAIL post_swap_psum: got %0d want 18", bottom_psum); end
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL swap_timing_err: got %b want 0", err); end
    endtask

    task automatic test_swap_error();
        do_reset();
        load_and_swap(8'd5);
        swap = 1;
        cycle();
        idle();
        tests++;
        if (err !== 1'b1) begin fails++; $display("FAIL empty_swap_err: got %b want 1", err); end
        mode = PROC; left_data = 8'd3; left_valid = 1; add_zero = 1;
        cycle();
        idle(); mode = HOLD;
        tests++;
        if (bottom_psum !== 32'd15) begin fails++; $display("FAIL empty_swap_active: got %0d want 15", bottom_psum); end
        for (int i = 0; i < 20; i++) begin
            cycle();
            tests++;
            if (err !== 1'b1) begin fails++; $display("FAIL err_sticky[%0d]: got %b want 1", i, err); end
        end
        do_reset();
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL err_clear: got %b want 0", err); end
    endtask

    task automatic test_align_error();
        do_reset();
        load_and_swap(8'd2);
        mode = PROC; left_data = 8'd6; left_valid = 1; top_psum = 32'd1; top_valid = 0; add_zero = 0;
        cycle();
        idle();
        tests++;
        if (bottom_valid !== 1'b0 || err !== 1'b1) begin
            fails++; $display("FAIL align_err: got bv=%b err=%b want bv=0 err=1", bottom_valid, err);
        end
    endtask

    task automatic test_overflow_reset();
        logic [31:0] want;
`ifdef PE_SAT_EN
        want = 32'h7FFFFFFF;
`else
        want = 32'h80000000;
`endif
        do_reset();
        load_and_swap(8'd1);
        mode = PROC; left_data = 8'd1; left_valid = 1; top_psum = 32'h7FFFFFFF; top_valid = 1;
        cycle();
        tests++;
        if (bottom_psum !== want) begin fails++; $display("FAIL overflow_psum: got %h want %h", bottom_psum, want); end
        w = 8'hA5; w_valid = 1; top_valid = 0; rst = 1;
        cycle();
        idle();
        tests++;
        if ({right_data, right_valid, bottom_psum, bottom_valid, w_out, w_valid_out, err} !== '0) begin
            fails++;
            $display("FAIL midstream_reset: got rd=%h rv=%b bp=%h bv=%b w=%h wv=%b err=%b, want all 0",
                     right_data, right_valid, bottom_psum, bottom_valid, w_out, w_valid_out, err);
        end
    endtask

    task automatic test_random();
        logic [61:0] got, want;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(63) == 0);
            mode       = 2'($urandom_range(3));
            add_zero   = ($urandom_range(3) == 0);
            left_data  = 8'($urandom);
            left_valid = ($urandom_range(7) != 0);
            top_psum   = ($urandom_range(7) == 0) ? 32'h7FFFFF00 + 32'($urandom_range(255)) : $urandom;
            top_valid  = ($urandom_range(7) != 0);
            w          = 8'($urandom);
            w_valid    = $urandom_range(1) == 1;
            swap       = ($urandom_range(3) == 0);
            cycle();
            got  = {right_data, right_valid, bottom_psum, bottom_valid, w_out, w_valid_out, err};
            want = {e_rdata, e_rvalid, e_bpsum, e_bvalid, e_w, e_wvalid, m_err};
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL random[%0d]: got rd=%h rv=%b bp=%h bv=%b w=%h wv=%b err=%b want rd=%h rv=%b bp=%h bv=%b w=%h wv=%b err=%b",
                         i, right_data, right_valid, bottom_psum, bottom_valid, w_out, w_valid_out, err,
                         e_rdata, e_rvalid, e_bpsum, e_bvalid, e_w, e_wvalid, m_err);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic_mac();
        test_signed();
        test_swap_timing();
        test_swap_error();
        test_align_error();
        test_overflow_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
